// File: rtl/player_command_sequencer.sv
`timescale 1ns/1ps
// player_command_sequencer: turns button levels and damage/heal events into one
// 16-bit player instruction per clock {opcode[15:12], operand[11:4], 4'h0}.
// Events are buffered in a small FIFO. Damage is gated by invincibility frames
// and movement is rate limited by a free-running period counter.
module player_command_sequencer #(
  parameter int unsigned MOVE_PERIOD   = 250000,
  parameter int unsigned IFRAME_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned INIT_HP       = 100,
  parameter int unsigned INIT_ATK      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_up,
  input  logic        btn_right,
  input  logic        btn_down,
  input  logic        dmg_valid,
  input  logic [7:0]  dmg_amount,
  input  logic        heal_valid,
  input  logic [7:0]  heal_amount,
  output logic [15:0] instruction,
  output logic        iframe,
  output logic        fifo_full,
  output logic        event_dropped
);

  localparam int unsigned MW = $clog2(MOVE_PERIOD);
  localparam int unsigned IW = (IFRAME_CYCLES > 1) ? $clog2(IFRAME_CYCLES) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 9;  // {is_damage, amount}

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_HEAL = 4'd1;
  localparam logic [3:0] OP_DMG  = 4'd2;
  localparam logic [3:0] OP_ATK  = 4'd4;
  localparam logic [3:0] OP_MOVE = 4'd5;
  localparam logic [3:0] OP_HP   = 4'd6;

  typedef enum logic [1:0] {S_IDLE, S_INIT_HP, S_INIT_ATK, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [MW-1:0] r_move_cnt;
  logic          r_move_due;
  logic [IW-1:0] r_iframe_cnt;

  logic [15:0]   w_instr_next;
  logic          w_pop;
  logic          w_push_dmg;
  logic          w_push_heal;
  logic          w_drop;
  logic          w_issue_dmg;
  logic          w_issue_move;
  logic          w_dmg_ok;
  logic          w_any_btn;
  logic          w_run;
  logic [CW-1:0] w_free;
  logic [EW-1:0] w_head;
  logic [7:0]    w_dir;

  assign w_any_btn = btn_left | btn_up | btn_right | btn_down;
  assign w_run     = (r_state == S_RUN) && !start;
  assign w_head    = r_mem[r_rd_ptr];
  assign fifo_full = (r_count == CW'(FIFO_DEPTH));

  // Next state, next instruction, FIFO push/pop decisions
  always_comb begin
    w_state_next = r_state;
    w_instr_next = {OP_NOP, 12'h000};
    w_pop        = 1'b0;
    w_push_dmg   = 1'b0;
    w_push_heal  = 1'b0;
    w_drop       = 1'b0;
    w_issue_dmg  = 1'b0;
    w_issue_move = 1'b0;
    w_dmg_ok     = 1'b0;
    w_free       = '0;
    if (btn_left)       w_dir = 8'd0;
    else if (btn_up)    w_dir = 8'd1;
    else if (btn_right) w_dir = 8'd2;
    else                w_dir = 8'd3;

    case (r_state)
      S_IDLE: ;
      S_INIT_HP: begin
        w_instr_next = {OP_HP, 8'(INIT_HP), 4'h0};
        w_state_next = S_INIT_ATK;
      end
      S_INIT_ATK: begin
        w_instr_next = {OP_ATK, 8'(INIT_ATK), 4'h0};
        w_state_next = S_RUN;
      end
      S_RUN: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (!w_head[8]) begin
            w_instr_next = {OP_HEAL, w_head[7:0], 4'h0};
          end else if (!iframe) begin
            w_instr_next = {OP_DMG, w_head[7:0], 4'h0};
            w_issue_dmg  = 1'b1;
          end
        end else if (r_move_due && w_any_btn) begin
          w_instr_next = {OP_MOVE, w_dir, 4'h0};
          w_issue_move = 1'b1;
        end
        // A same-cycle pop frees a slot; damage claims a slot before heal
        w_free   = CW'(FIFO_DEPTH) - r_count + CW'(w_pop);
        w_dmg_ok = dmg_valid && !iframe;
        if (w_dmg_ok) begin
          if (w_free != '0) w_push_dmg = 1'b1;
          else              w_drop     = 1'b1;
        end
        if (heal_valid) begin
          if (w_free > CW'(w_push_dmg)) w_push_heal = 1'b1;
          else                          w_drop      = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (start) begin
      w_state_next = S_INIT_HP;
      w_instr_next = {OP_NOP, 12'h000};
      w_pop        = 1'b0;
      w_push_dmg   = 1'b0;
      w_push_heal  = 1'b0;
      w_drop       = 1'b0;
      w_issue_dmg  = 1'b0;
      w_issue_move = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Registered instruction and drop pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction   <= 16'h0000;
      event_dropped <= 1'b0;
    end else begin
      instruction   <= w_instr_next;
      event_dropped <= w_drop;
    end
  end

  // FIFO pointers and occupancy; start flushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (start) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_wr_ptr <= r_wr_ptr + AW'(w_push_dmg) + AW'(w_push_heal);
      r_count  <= r_count + CW'(w_push_dmg) + CW'(w_push_heal) - CW'(w_pop);
    end
  end

  // FIFO storage; heal lands behind damage when both are written
  always_ff @(posedge clk) begin
    if (w_push_dmg)  r_mem[r_wr_ptr] <= {1'b1, dmg_amount};
    if (w_push_heal) r_mem[r_wr_ptr + AW'(w_push_dmg)] <= {1'b0, heal_amount};
  end

  // Movement period counter and single-step move_due flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_move_cnt <= MW'(MOVE_PERIOD - 1);
      r_move_due <= 1'b0;
    end else if (start) begin
      r_move_cnt <= MW'(MOVE_PERIOD - 1);
      r_move_due <= 1'b0;
    end else begin
      if (w_run) begin
        if (r_move_cnt == '0) r_move_cnt <= MW'(MOVE_PERIOD - 1);
        else                  r_move_cnt <= r_move_cnt - MW'(1);
      end
      r_move_due <= w_any_btn &&
                    ((w_run && (r_move_cnt == '0)) || (r_move_due && !w_issue_move));
    end
  end

  // Invincibility window: IFRAME_CYCLES cycles starting after the damage issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iframe_cnt <= '0;
      iframe       <= 1'b0;
    end else if (start) begin
      r_iframe_cnt <= '0;
      iframe       <= 1'b0;
    end else if (w_issue_dmg) begin
      r_iframe_cnt <= IW'(IFRAME_CYCLES - 1);
      iframe       <= 1'b1;
    end else if (r_iframe_cnt != '0) begin
      r_iframe_cnt <= r_iframe_cnt - IW'(1);
      iframe       <= 1'b1;
    end else begin
      iframe       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_player_command_sequencer.sv
`timescale 1ns/1ps
// Directed bench: instance A has an 8-cycle invincibility window, instance B a
// 1-cycle window so the FIFO can be driven to overflow. Both share stimulus.
module tb_player_command_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        btn_left, btn_up, btn_right, btn_down;
  logic        dmg_valid, heal_valid;
  logic [7:0]  dmg_amount, heal_amount;
  logic [15:0] instr_a, instr_b;
  logic        iframe_a, iframe_b, full_a, full_b, drop_a, drop_b;

  int n_checks = 0;
  int n_fail   = 0;

  player_command_sequencer #(
    .MOVE_PERIOD(4), .IFRAME_CYCLES(8), .FIFO_DEPTH(4), .INIT_HP(100), .INIT_ATK(10)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(start),
    .btn_left(btn_left), .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down),
    .dmg_valid(dmg_valid), .dmg_amount(dmg_amount),
    .heal_valid(heal_valid), .heal_amount(heal_amount),
    .instruction(instr_a), .iframe(iframe_a), .fifo_full(full_a), .event_dropped(drop_a)
  );

  player_command_sequencer #(
    .MOVE_PERIOD(4), .IFRAME_CYCLES(1), .FIFO_DEPTH(4), .INIT_HP(100), .INIT_ATK(10)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start),
    .btn_left(btn_left), .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down),
    .dmg_valid(dmg_valid), .dmg_amount(dmg_amount),
    .heal_valid(heal_valid), .heal_amount(heal_amount),
    .instruction(instr_b), .iframe(iframe_b), .fifo_full(full_b), .event_dropped(drop_b)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    btn_left = 1'b0; btn_up = 1'b0; btn_right = 1'b0; btn_down = 1'b0;
    dmg_valid = 1'b0; heal_valid = 1'b0; dmg_amount = 8'd0; heal_amount = 8'd0;

    // Reset values
    tick(); tick();
    chk("rst_instr",  instr_a, 16'h0000);
    chk("rst_iframe", 16'(iframe_a), 16'h0000);
    chk("rst_full",   16'(full_a), 16'h0000);
    chk("rst_drop",   16'(drop_a), 16'h0000);
    rst = 1'b0;
    tick();

    // Events in IDLE are ignored
    dmg_valid = 1'b1; dmg_amount = 8'd5; heal_valid = 1'b1; heal_amount = 8'd20;
    tick();
    dmg_valid = 1'b0; heal_valid = 1'b0;
    chk("idle_nop",  instr_a, 16'h0000);
    chk("idle_drop", 16'(drop_a), 16'h0000);

    // Start sequence; a heal held through INIT must not be queued
    start = 1'b1; tick(); start = 1'b0;
    chk("start_nop", instr_a, 16'h0000);
    heal_valid = 1'b1;
    tick(); chk("init_hp",  instr_a, 16'h6640);
    tick(); chk("init_atk", instr_a, 16'h40A0);
    heal_valid = 1'b0;
    tick(); chk("run_nop0", instr_a, 16'h0000);
    tick(); chk("run_nop1", instr_a, 16'h0000);

    // Damage 5 and the 8-cycle invincibility window (instance A)
    dmg_valid = 1'b1; dmg_amount = 8'd5; tick(); dmg_valid = 1'b0;
    chk("dmg_lat",     instr_a, 16'h0000);
    chk("dmg_if_low",  16'(iframe_a), 16'h0000);
    tick();
    chk("dmg5",        instr_a, 16'h2050);
    chk("if_rise",     16'(iframe_a), 16'h0001);
    dmg_valid = 1'b1; dmg_amount = 8'd3; tick(); dmg_valid = 1'b0;
    chk("if_discard_nop",  instr_a, 16'h0000);
    chk("if_discard_drop", 16'(drop_a), 16'h0000);
    tick(); chk("if_block", instr_a, 16'h0000);
    repeat (5) tick();
    chk("if_hold_last", 16'(iframe_a), 16'h0001);
    tick();
    chk("if_fall", 16'(iframe_a), 16'h0000);
    dmg_valid = 1'b1; dmg_amount = 8'd3; tick(); dmg_valid = 1'b0;
    tick(); chk("dmg3_after_window", instr_a, 16'h2030);

    // Same-cycle damage + heal into an empty FIFO (instance B, window now over)
    tick();
    dmg_valid = 1'b1; dmg_amount = 8'd5; heal_valid = 1'b1; heal_amount = 8'd20;
    tick();
    dmg_valid = 1'b0; heal_valid = 1'b0;
    tick(); chk("pair_dmg",  instr_b, 16'h2050);
    chk("pair_iframe", 16'(iframe_b), 16'h0001);
    tick(); chk("pair_heal", instr_b, 16'h1140);
    tick(); chk("pair_idle", instr_b, 16'h0000);

    // Movement rate limiting, direction priority, heal before move
    btn_right = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    chk("mv_wait",   instr_a, 16'h0000);
    tick(); chk("mv_right0", instr_a, 16'h5020);
    tick(); chk("mv_once",   instr_a, 16'h0000);
    repeat (2) tick();
    chk("mv_gap",    instr_a, 16'h0000);
    tick(); chk("mv_right1", instr_a, 16'h5020);
    btn_right = 1'b0; btn_left = 1'b1; btn_down = 1'b1;
    repeat (4) tick();
    chk("mv_left_over_down", instr_a, 16'h5000);
    repeat (2) tick();
    heal_valid = 1'b1; heal_amount = 8'd20; tick(); heal_valid = 1'b0;
    tick(); chk("mv_heal_first", instr_a, 16'h1140);
    tick(); chk("mv_after_heal", instr_a, 16'h5000);
    btn_left = 1'b0; btn_down = 1'b0;

    // Overflow: damage+heal pairs every cycle (instance B)
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    dmg_valid = 1'b1; dmg_amount = 8'd5; heal_valid = 1'b1; heal_amount = 8'd20;
    tick(); chk("ovf_a0", instr_b, 16'h0000);
    tick(); chk("ovf_a1", instr_b, 16'h2050);
    tick(); chk("ovf_a2", instr_b, 16'h1140);
    chk("ovf_full_a2", 16'(full_b), 16'h0000);
    tick(); chk("ovf_a3", instr_b, 16'h2050);
    chk("ovf_full_a3", 16'(full_b), 16'h0001);
    tick(); chk("ovf_a4", instr_b, 16'h1140);
    chk("ovf_drop_a4", 16'(drop_b), 16'h0000);
    tick(); chk("ovf_a5", instr_b, 16'h1140);
    chk("ovf_drop_a5", 16'(drop_b), 16'h0001);
    tick(); chk("ovf_a6", instr_b, 16'h2050);
    chk("ovf_drop_a6", 16'(drop_b), 16'h0001);
    chk("ovf_full_a6", 16'(full_b), 16'h0001);
    dmg_valid = 1'b0; heal_valid = 1'b0;
    tick(); chk("ovf_a7", instr_b, 16'h1140);
    chk("ovf_drop_a7", 16'(drop_b), 16'h0000);
    chk("ovf_full_a7", 16'(full_b), 16'h0000);
    tick(); chk("ovf_a8",  instr_b, 16'h1140);
    tick(); chk("ovf_a9",  instr_b, 16'h2050);
    tick(); chk("ovf_a10_discard", instr_b, 16'h0000);
    tick(); chk("ovf_a11", instr_b, 16'h0000);

    // Async reset with three events queued
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    dmg_valid = 1'b1; dmg_amount = 8'd5; heal_valid = 1'b1; heal_amount = 8'd20;
    tick(); tick();
    dmg_valid = 1'b0; heal_valid = 1'b0;
    chk("pre_rst_instr", instr_b, 16'h2050);
    rst = 1'b1;
    #1;
    chk("arst_instr",    instr_b, 16'h0000);
    chk("arst_iframe_b", 16'(iframe_b), 16'h0000);
    chk("arst_iframe_a", 16'(iframe_a), 16'h0000);
    chk("arst_full",     16'(full_b), 16'h0000);
    #2;
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle", instr_b, 16'h0000);
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk("post_rst_hp",  instr_b, 16'h6640);
    tick(); chk("post_rst_atk", instr_b, 16'h40A0);
    tick(); chk("post_rst_run0", instr_b, 16'h0000);
    tick(); chk("post_rst_run1", instr_b, 16'h0000);
    tick(); chk("post_rst_run2", instr_b, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_command_sequencer.md
# player_command_sequencer

Upstream command generator for the player datapath. Collects button levels and damage/heal events from the game logic, buffers events in a small FIFO, and applies invincibility frames and movement rate limiting. Drives exactly one 16-bit player instruction per clock: an opcode in [15:12], an operand in [11:4], and [3:0] always zero. The player stage consumes this word on every rising clk edge.

## Interface
- MOVE_PERIOD, 250000 — clk cycles between movement opportunities (≥2)
- IFRAME_CYCLES, 1000000 — invincibility window after an issued damage (≥1)
- FIFO_DEPTH, 4 — event FIFO entries (power of two, ≥2)
- INIT_HP, 100 — HP loaded by the start sequence
- INIT_ATK, 10 — ATK loaded by the start sequence

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; (re)starts the game
- btn_left, btn_up, btn_right, btn_down  in  1 each  synchronised button levels
- dmg_valid  in  1  damage event strobe
- dmg_amount  in  8  damage value
- heal_valid  in  1  heal event strobe
- heal_amount  in  8  heal value
- instruction  out  16  registered player instruction
- iframe  out  1  invincibility active
- fifo_full  out  1  event FIFO full (combinational from count)
- event_dropped  out  1  registered one-cycle pulse; an event was lost to overflow

## Operation
- Opcodes used: 0 NOP, 1 heal, 2 damage, 4 set ATK, 5 move, 6 set HP. Move operands: 0 left, 1 up, 2 right, 3 down.
- Reset values: FSM=IDLE, instruction=16'h0000, iframe=0, event_dropped=0, FIFO empty, move counter=MOVE_PERIOD-1, move_due=0, iframe counter=0.
- FSM states:
  - IDLE → INIT_HP on start. NOP is output. All events are ignored.
  - INIT_HP issues {6,INIT_HP,0}, → INIT_ATK.
  - INIT_ATK issues {4,INIT_ATK,0}, → RUN.
  - RUN: steady state.
- start in any state:
  - flushes the FIFO, clears iframe and its counter, reloads the move counter, clears move_due;
  - next state is INIT_HP.
- Enqueue occurs in RUN only. Entry = {type, amount}.
  - dmg_valid while iframe=1: discarded silently, no event_dropped.
  - dmg_valid and heal_valid in the same cycle: damage is written first, then heal.
  - If only one slot is free, damage is kept and heal is dropped.
  - Any event that cannot be written sets event_dropped for the next cycle.
  - A pop and a push in the same cycle on a full FIFO are both allowed (count unchanged).
- Issue in RUN, one per cycle, in priority order:
  1. FIFO non-empty → pop the head.
     - Heal → {1,amount,0}.
     - Damage with iframe=0 → {2,amount,0}; load the iframe counter with IFRAME_CYCLES-1; iframe=1 from the next cycle.
     - Damage popped while iframe=1 → discarded, NOP issued.
  2. Else if move_due and any button held → {5,dir,0}, clear move_due.
     - Direction priority: left > up > right > down.
  3. Else NOP.
- Move counter:
  - Counts down in RUN. At 0 it reloads MOVE_PERIOD-1 and sets move_due.
  - move_due is cleared on a move issue, or in any cycle where no button is held.
  - move_due never accumulates beyond one step.
- Iframe counter: decrements while non-zero; iframe=1 while the counter is non-zero.
- Arithmetic: amounts pass through unmodified (8 bits); no saturation here, since the player stage clamps.

## Timing
- instruction is registered. Every non-NOP word is held exactly one cycle, then NOP unless another issue follows.
- start sampled at edge k: {6,INIT_HP} after edge k+1, {4,INIT_ATK} after edge k+2, RUN from edge k+3.
- Event sampled at edge k into an empty FIFO: its instruction is visible after edge k+1.
- Back-to-back events issue on consecutive cycles.
- iframe rises after the edge that issues the damage. It stays high for IFRAME_CYCLES cycles.
- Async rst mid-operation: all outputs go to reset values immediately; the FSM returns to IDLE.

## Test plan
- Reset, pulse start with defaults → instruction 16'h6640, then 16'h40A0, then 16'h0000; no events accepted before RUN.
- RUN, dmg_valid amount 5 → 16'h2050 one cycle; iframe high for IFRAME_CYCLES (set 8). Damage 3 during the window → no issue. Damage after the window expires → issued.
- Same-cycle dmg 5 + heal 20 with an empty FIFO → 16'h2050 then 16'h1140 on consecutive cycles.
- FIFO_DEPTH=4, MOVE_PERIOD=4, IFRAME_CYCLES=1, hold btn_right: a move issues {5,2,0}=16'h5020 every 4 cycles. left+down held → 16'h5000. Heal pending at move_due → heal first, move next cycle.
- Fill FIFO with 5 heals in consecutive cycles while issue is stalled via start/INIT (or a forced full) → fifo_full=1, event_dropped pulses exactly once per lost event.
- Assert rst mid-burst with FIFO holding 3 events → instruction=0, iframe=0 immediately. After release, no queued event is ever issued.
